disp_scan_ctrl: RTL
===================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, SHOW cycles per digit (1 kHz per digit at 100 MHz); legal range 2..2^20.
REQ-002 Parameter DEAD_CYCLES, default 16, all-anodes-off cycles between digits; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 en  input  1  scan enable; low = display dark and scan frozen.
REQ-006 upd_req  input  1  new display values offered this cycle.
REQ-007 upd_time  input  8  time BCD, [7:4] tens, [3:0] ones.
REQ-008 upd_score  input  8  score BCD, [7:4] tens, [3:0] ones.
REQ-009 upd_ack  output  1  one-cycle pulse: offer captured.
REQ-010 time_tens, time_ones, score_tens, score_ones  output  4 each  committed digits, wired to the 4:1 digit mux data inputs.
REQ-011 sel  output  2  digit mux select: 00 time tens, 01 time ones, 10 score tens, 11 score ones.
REQ-012 an  output  4  active-low anodes; an[3] time tens, an[2] time ones, an[1] score tens, an[0] score ones.
REQ-013 frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-014 FSM states BLANK and SHOW; prescaler counter sized to REFRESH_DIV.
REQ-015 SHOW lasts exactly REFRESH_DIV cycles with only the anode matching sel driven low.
REQ-016 On the last SHOW cycle: go to BLANK, sel increments modulo 4 (11 wraps to 00).
REQ-017 BLANK lasts exactly DEAD_CYCLES cycles with an=4'b1111, then goes to SHOW.
REQ-018 Frame boundary = SHOW->BLANK transition with sel=11; frame_tick asserts in the cycle sel becomes 00.
REQ-019 Pending buffer (16 bits + full flag): when upd_req=1 and pending empty, capture both bytes, set full, pulse upd_ack next cycle.
REQ-020 upd_req while pending full is ignored (no capture, no ack); requester retries.
REQ-021 At frame boundary with pending full: copy pending to the committed digit outputs and clear full in the same edge, so new values first show with sel=00.
REQ-022 upd_req coinciding with a commit edge is captured into the freshly emptied buffer (full stays 1, ack pulses).
REQ-023 Non-BCD nibbles (A-F) are committed unchanged; no checking.
REQ-024 en=0: an=4'b1111, FSM/prescaler/sel hold; update capture and commit continue only if frame boundary reached, i.e. commit is frozen while en=0.
REQ-025 en rising: resumes from held state and count.

Reset
REQ-026 rst_n low forces immediately: state BLANK, prescaler 0, sel=00, an=4'b1111, committed digits 0, pending empty, upd_ack=0, frame_tick=0.
REQ-027 Reset mid-SHOW or with pending full discards the pending data; no ack issued for it.
REQ-028 After rst_n rises, first SHOW begins after DEAD_CYCLES cycles with sel=00.

Configuration
REQ-029 Macro DISP_LEAD_ZERO_BLANK_EN: when defined, an[3] stays high while time_tens=0 and an[1] stays high while score_tens=0 (sequence timing unchanged); when undefined, all four digits always light in turn.

Structure
REQ-030 Shared package disp_pkg holds state enum, sel encodings (SEL_TIME_TENS..SEL_SCORE_ONES) and the ANODES_OFF constant.
REQ-031 One sub-module, disp_prescaler (parameterised down-counter with terminal-count output), used for both SHOW and BLANK durations.

Verification (REFRESH_DIV=4, DEAD_CYCLES=1)
REQ-032 Reset release, en=1 -> an: 1111 x1, 0111 x4, 1111 x1, 1011 x4 (sel=01), ..., 1110 x4, frame_tick on return to sel=00.
REQ-033 upd_req with time=8'h42, score=8'h07 mid-frame -> upd_ack next cycle; outputs stay 0 until frame boundary, then time_tens=4, time_ones=2, score_tens=0, score_ones=7.
REQ-034 Second upd_req before boundary -> no ack, values unchanged; upd_req on the commit edge -> ack, pending full after commit.
REQ-035 en=0 during SHOW sel=10 for 7 cycles -> an=1111, sel holds 10; en=1 -> an=1101 for remaining count.
REQ-036 rst_n low mid-SHOW with pending full -> an=1111, sel=00 asynchronously; no later commit of discarded data.
REQ-037 DISP_LEAD_ZERO_BLANK_EN defined, time=8'h05 -> an[3] never low; undefined -> an[3] low in sel=00 slot.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 4-digit display scanner.
package disp_pkg;

  typedef enum logic [0:0] {
    StBlank,
    StShow
  } disp_state_e;

  localparam logic [1:0] SEL_TIME_TENS  = 2'd0;
  localparam logic [1:0] SEL_TIME_ONES  = 2'd1;
  localparam logic [1:0] SEL_SCORE_TENS = 2'd2;
  localparam logic [1:0] SEL_SCORE_ONES = 2'd3;

  localparam logic [3:0] ANODES_OFF = 4'b1111;

  // Active-low anode pattern lighting only the digit addressed by sel.
  function automatic logic [3:0] anode_for_sel(input logic [1:0] sel);
    logic [3:0] a;
    a = ANODES_OFF;
    case (sel)
      SEL_TIME_TENS:  a = 4'b0111;
      SEL_TIME_ONES:  a = 4'b1011;
      SEL_SCORE_TENS: a = 4'b1101;
      SEL_SCORE_ONES: a = 4'b1110;
      default:        a = ANODES_OFF;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Phase-duration counter for the display scanner. Counts down from zero (modulo 2^Width)
// so the idle/reset value is 0; tc_o marks the last cycle of a phase of last_i+1 cycles.
module disp_prescaler #(
  parameter int unsigned Width = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] last_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] tc_val;

  // Terminal value is -(last_i) in two's complement, i.e. last_i decrements below zero.
  assign tc_val = '0 - last_i;
  assign tc_o   = (cnt_q == tc_val);

  // Hold while disabled; restart at zero after the terminal cycle so the next phase starts clean.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (tc_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q - Width'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed 7-segment display (time + score).
// Optional build macro: DISP_LEAD_ZERO_BLANK_EN keeps a zero tens digit dark.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       upd_req,
  input  logic [7:0] upd_time,
  input  logic [7:0] upd_score,
  output logic       upd_ack,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int unsigned MaxLen = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxLen);

  disp_state_e      state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CntW-1:0]  phase_last;
  logic             phase_tc;
  logic             advance;
  logic             frame_edge;
  logic             commit;
  logic             capture;

  logic             pend_full_q, pend_full_d;
  logic [15:0]      pend_q, pend_d;
  logic [15:0]      digits_q, digits_d;
  logic             ack_q;
  logic             tick_q;

  assign phase_last = (state_q == StShow) ? CntW'(REFRESH_DIV - 1) : CntW'(DEAD_CYCLES - 1);

  disp_prescaler #(
    .Width (CntW)
  ) u_prescaler (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (en),
    .last_i (phase_last),
    .tc_o   (phase_tc)
  );

  assign advance    = en && phase_tc;
  assign frame_edge = advance && (state_q == StShow) && (sel_q == SEL_SCORE_ONES);
  assign commit     = frame_edge && pend_full_q;
  // A commit empties the buffer on the same edge, so a coincident offer still fits.
  assign capture    = upd_req && (!pend_full_q || commit);

  // Phase sequencing: BLANK -> SHOW -> BLANK, advancing the digit on each SHOW exit.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      StBlank: begin
        if (advance) state_d = StShow;
      end
      StShow: begin
        if (advance) begin
          state_d = StBlank;
          sel_d   = sel_q + 2'd1;
        end
      end
      default: state_d = StBlank;
    endcase
  end

  // Pending buffer and committed digits; commit only happens at a frame boundary.
  always_comb begin
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    digits_d    = digits_q;
    if (commit) begin
      digits_d    = pend_q;
      pend_full_d = 1'b0;
    end
    if (capture) begin
      pend_d      = {upd_time, upd_score};
      pend_full_d = 1'b1;
    end
  end

  // State, buffer and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StBlank;
      sel_q       <= SEL_TIME_TENS;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      digits_q    <= '0;
      ack_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      digits_q    <= digits_d;
      ack_q       <= capture;
      tick_q      <= frame_edge;
    end
  end

  // Anode drive: dark during BLANK or when disabled, else light the selected digit.
  always_comb begin
    an = ANODES_OFF;
    if (en && (state_q == StShow)) begin
      an = anode_for_sel(sel_q);
`ifdef DISP_LEAD_ZERO_BLANK_EN
      if (digits_q[15:12] == 4'd0) an[3] = 1'b1;
      if (digits_q[7:4] == 4'd0) an[1] = 1'b1;
`endif
    end
  end

  assign sel        = sel_q;
  assign upd_ack    = ack_q;
  assign frame_tick = tick_q;
  assign time_tens  = digits_q[15:12];
  assign time_ones  = digits_q[11:8];
  assign score_tens = digits_q[7:4];
  assign score_ones = digits_q[3:0];

endmodule
